// File: rtl/pe_pkg.sv
// Shared PE-array definitions: tile geometry, tile/row types and small helpers
// used by both the array and its result drain.
package pe_pkg;

  localparam int DW     = 16;  // fixed-point 7.9 PE result
  localparam int COLS   = 16;
  localparam int ROWS   = 2;
  localparam int TAG_W  = 3;
  localparam int DROP_W = 8;

  typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] pe_tile_t;
  typedef logic [COLS-1:0][DW-1:0]           pe_row_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/tile_fifo.sv
// DEPTH-entry tile store with push/pop; a push into a full store is accepted
// when the head is popped in the same cycle.
module tile_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // NOTE: the payload array has no reset; r_count alone says which slots are
  // live, so resetting wide storage would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/pe_array_drain.sv
// Captures rounded PE tiles, buffers them and streams one row per beat;
// tiles arriving with no free slot are dropped and counted.
module pe_array_drain #(
  parameter int ROWS  = pe_pkg::ROWS,
  parameter int COLS  = pe_pkg::COLS,
  parameter int DW    = pe_pkg::DW,
  parameter int DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ROWS-1:0][COLS-1:0][DW-1:0]       array_out,
  input  logic                                    rounder_valid,
  input  logic [pe_pkg::TAG_W-1:0]                round_number,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [COLS*DW-1:0]                      out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [pe_pkg::TAG_W-1:0]                out_tag,
  output logic                                    out_last,
  output logic                                    overflow,
  input  logic                                    overflow_clr,
  output logic [pe_pkg::DROP_W-1:0]               drop_count,
  output logic                                    busy
);

  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TAG_W  = pe_pkg::TAG_W;
  localparam int DROP_W = pe_pkg::DROP_W;
  localparam int TILE_W = ROWS * COLS * DW;
  localparam int ENT_W  = TAG_W + TILE_W;

  logic [ENT_W-1:0]                w_head;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] w_head_tile;
  logic [TAG_W-1:0]                w_head_tag;
  logic                            w_full;
  logic                            w_empty;
  logic                            w_fire;
  logic                            w_last;
  logic                            w_pop;
  logic                            w_drop;

  logic [RW-1:0]     r_beat;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  assign w_fire = !w_empty && out_ready;
  assign w_last = (r_beat == RW'(ROWS - 1));
  assign w_pop  = w_fire && w_last;
  // A full buffer still takes the strobe when the head tile leaves this cycle.
  assign w_drop = rounder_valid && w_full && !w_pop;

  tile_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_tile_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (rounder_valid),
    .i_pop   (w_pop),
    .i_data  ({round_number, array_out}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_tag, w_head_tile} = w_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (w_fire) begin
      r_beat <= w_last ? '0 : r_beat + RW'(1);
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= overflow_clr ? DROP_W'(1) : pe_pkg::sat_inc(r_drop_count);
    end else if (overflow_clr) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  // Outputs come only from stored slots; idle outputs are forced to zero.
  assign out_valid  = !w_empty;
  assign busy       = !w_empty;
  assign out_row    = r_beat;
  assign out_last   = out_valid && w_last;
  assign out_data   = out_valid ? w_head_tile[r_beat] : '0;
  assign out_tag    = out_valid ? w_head_tag : '0;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pe_array_drain.sv
// Directed and randomized checks of pe_array_drain against a queue-based model
// of the tile buffer, beat serializer and drop counters.
module tb_pe_array_drain;

  localparam int ROWS  = 2;
  localparam int COLS  = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] tile_t;
  typedef struct packed {
    logic [2:0] tag;
    tile_t      tile;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst_n;
  tile_t              array_out;
  logic               rounder_valid;
  logic [2:0]         round_number;
  logic               out_valid;
  logic               out_ready;
  logic [COLS*DW-1:0] out_data;
  logic [0:0]         out_row;
  logic [2:0]         out_tag;
  logic               out_last;
  logic               overflow;
  logic               overflow_clr;
  logic [7:0]         drop_count;
  logic               busy;

  pe_array_drain #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .array_out     (array_out),
    .rounder_valid (rounder_valid),
    .round_number  (round_number),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_tag       (out_tag),
    .out_last      (out_last),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored tiles plus counters.
  ent_t q[$];
  int   m_beat;
  bit   m_ovf;
  int   m_dc;

  int n_checks = 0;
  int n_pass   = 0;

  logic [COLS*DW-1:0] snap_data;
  logic [2:0]         snap_tag;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic model_check();
    bit v;
    v = (q.size() != 0);
    check("out_valid", 256'(out_valid), 256'(v));
    check("busy", 256'(busy), 256'(v));
    check("out_row", 256'(out_row), 256'(m_beat));
    check("out_last", 256'(out_last), 256'(v && (m_beat == ROWS - 1)));
    check("overflow", 256'(overflow), 256'(m_ovf));
    check("drop_count", 256'(drop_count), 256'(m_dc));
    if (v) begin
      check("out_data", 256'(out_data), 256'(q[0].tile[m_beat]));
      check("out_tag", 256'(out_tag), 256'(q[0].tag));
    end
  endtask

  // One clock: model evaluated on the pre-edge inputs, outputs checked at negedge.
  task automatic cycle();
    bit   fire, pop, free, drop;
    ent_t e;
    fire = (q.size() != 0) && (out_ready === 1'b1);
    pop  = fire && (m_beat == ROWS - 1);
    free = (q.size() < DEPTH) || pop;
    drop = (rounder_valid === 1'b1) && !free;
    e.tag  = round_number;
    e.tile = array_out;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      q.delete();
      m_beat = 0;
      m_ovf  = 0;
      m_dc   = 0;
    end else begin
      if (fire) begin
        if (pop) begin
          void'(q.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (rounder_valid === 1'b1 && free) q.push_back(e);
      if (drop) begin
        m_ovf = 1;
        m_dc  = overflow_clr ? 1 : ((m_dc >= 255) ? 255 : m_dc + 1);
      end else if (overflow_clr === 1'b1) begin
        m_ovf = 0;
        m_dc  = 0;
      end
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic rand_tile();
    for (int r = 0; r < ROWS; r++)
      for (int n = 0; n < COLS; n++)
        array_out[r][n] = DW'($urandom);
  endtask

  task automatic strobe(input logic [2:0] tag);
    rand_tile();
    round_number  = tag;
    rounder_valid = 1'b1;
    cycle();
    rounder_valid = 1'b0;
    round_number  = 3'($urandom);
    rand_tile();
  endtask

  task automatic drain();
    out_ready     = 1'b1;
    rounder_valid = 1'b0;
    for (int i = 0; i < 4 * DEPTH * ROWS && q.size() != 0; i++) cycle();
    check("drain_empty", 256'(busy), 256'(0));
  endtask

  initial begin
    rst_n         = 1'b0;
    array_out     = '0;
    rounder_valid = 1'b0;
    round_number  = '0;
    out_ready     = 1'b0;
    overflow_clr  = 1'b0;
    cycle();
    cycle();
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_data", 256'(out_data), 256'(0));
    check("rst_tag", 256'(out_tag), 256'(0));

    // Single tile with lane n of row r = r*256+n.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int n = 0; n < COLS; n++)
        array_out[r][n] = DW'(r * 256 + n);
    round_number  = 3'd5;
    rounder_valid = 1'b1;
    cycle();
    rounder_valid = 1'b0;
    array_out     = '0;
    check("t1_valid", 256'(out_valid), 256'(1));
    check("t1_r0_lane3", 256'(out_data[3*DW +: DW]), 256'(16'h0003));
    check("t1_tag", 256'(out_tag), 256'(5));
    check("t1_last0", 256'(out_last), 256'(0));
    cycle();
    check("t1_r1_lane15", 256'(out_data[15*DW +: DW]), 256'(16'h010f));
    check("t1_last1", 256'(out_last), 256'(1));
    cycle();
    check("t1_idle", 256'(busy), 256'(0));

    // Back-pressure: row 0 held for 10 cycles, then two back-to-back beats.
    out_ready = 1'b0;
    strobe(3'd6);
    snap_data = out_data;
    snap_tag  = out_tag;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t2_hold_data", 256'(out_data), 256'(snap_data));
      check("t2_hold_tag", 256'(out_tag), 256'(snap_tag));
      check("t2_hold_row", 256'(out_row), 256'(0));
    end
    out_ready = 1'b1;
    cycle();
    check("t2_beat1_valid", 256'(out_valid), 256'(1));
    check("t2_beat1_row", 256'(out_row), 256'(1));
    cycle();
    check("t2_done", 256'(busy), 256'(0));

    // Push while full, coincident with the head's last-beat handshake.
    out_ready = 1'b0;
    strobe(3'd1);
    strobe(3'd2);
    out_ready = 1'b1;
    cycle();
    rand_tile();
    round_number  = 3'd3;
    rounder_valid = 1'b1;
    cycle();
    rounder_valid = 1'b0;
    check("t3_no_ovf", 256'(overflow), 256'(0));
    check("t3_head2", 256'(out_tag), 256'(2));
    cycle();
    cycle();
    check("t3_head3", 256'(out_tag), 256'(3));
    drain();

    // Fill and drop: third strobe is lost.
    out_ready = 1'b0;
    strobe(3'd1);
    strobe(3'd2);
    strobe(3'd3);
    check("t4_ovf", 256'(overflow), 256'(1));
    check("t4_dc", 256'(drop_count), 256'(1));
    out_ready = 1'b1;
    cycle();
    check("t4_tag1_r1", 256'({out_tag, out_row}), 256'({3'd1, 1'b1}));
    cycle();
    check("t4_tag2_r0", 256'({out_tag, out_row}), 256'({3'd2, 1'b0}));
    drain();

    // Clear coincident with a drop: the drop wins.
    out_ready = 1'b0;
    strobe(3'd0);
    strobe(3'd1);
    strobe(3'd2);
    check("t5_dc2", 256'(drop_count), 256'(2));
    overflow_clr = 1'b1;
    strobe(3'd3);
    check("t5_set_wins_ovf", 256'(overflow), 256'(1));
    check("t5_set_wins_dc", 256'(drop_count), 256'(1));
    cycle();
    overflow_clr = 1'b0;
    check("t5_clr_ovf", 256'(overflow), 256'(0));
    check("t5_clr_dc", 256'(drop_count), 256'(0));
    drain();

    // Reset mid-tile, then a clean tile.
    out_ready = 1'b1;
    strobe(3'd7);
    cycle();
    rst_n = 1'b0;
    cycle();
    check("t6_rst_valid", 256'(out_valid), 256'(0));
    check("t6_rst_row", 256'(out_row), 256'(0));
    check("t6_rst_last", 256'(out_last), 256'(0));
    check("t6_rst_data", 256'(out_data), 256'(0));
    rst_n = 1'b1;
    strobe(3'd4);
    check("t6_tag4", 256'({out_valid, out_tag, out_row}), 256'({1'b1, 3'd4, 1'b0}));
    drain();

    // drop_count saturates at 255.
    out_ready     = 1'b0;
    rounder_valid = 1'b1;
    for (int i = 0; i < 262; i++) begin
      round_number = 3'($urandom);
      rand_tile();
      cycle();
    end
    rounder_valid = 1'b0;
    check("t7_sat", 256'(drop_count), 256'(255));
    overflow_clr = 1'b1;
    cycle();
    overflow_clr = 1'b0;
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rounder_valid = ($urandom_range(0, 2) == 0);
      round_number  = 3'($urandom);
      rand_tile();
      out_ready     = ($urandom_range(0, 3) != 0);
      overflow_clr  = ($urandom_range(0, 15) == 0);
      cycle();
    end
    overflow_clr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_array_drain.md
Name: pe_array_drain

Overview:
- Consumer side of the PE array result interface.
- Captures each rounded 2x16 result tile when the array asserts rounder_valid, tagged with round_number.
- Buffers up to DEPTH tiles and serializes them as one 256-bit row per beat on a valid/ready stream toward the output buffer / writeback path.
- Detects and flags tiles lost to back-pressure.

Parameters:
- ROWS, 2, PE rows per tile (beats per tile)
- COLS, 16, PEs per row
- DW, 16, bits per PE result (fixed-point 7.9)
- DEPTH, 2, tile slots in capture buffer (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- array_out  in  [ROWS-1:0][COLS-1:0][DW-1:0]  PE array results, valid only with rounder_valid
- rounder_valid  in  1  single-cycle tile-valid strobe from array
- round_number  in  3  tile tag (accumulation slot), sampled with rounder_valid
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_data  out  COLS*DW  row beat; out_data[n*DW+:DW] = tile[row][n]
- out_row  out  $clog2(ROWS)  row index of current beat
- out_tag  out  3  round_number of current tile
- out_last  out  1  final beat of tile (row == ROWS-1)
- overflow  out  1  sticky: tile dropped since reset/clear
- overflow_clr  in  1  clears overflow
- drop_count  out  8  saturating count of dropped tiles
- busy  out  1  buffer non-empty

Behaviour:
- Reset (rst_n=0 at clk edge): buffer empty, write/read pointers = 0, beat index = 0, out_valid=0, out_last=0, out_row=0, out_tag=0, out_data=0, overflow=0, drop_count=0, busy=0. Reset mid-stream discards all buffered tiles; no partial beats afterward.
- Capture:
  - On a cycle with rounder_valid=1 and a free slot, store array_out and round_number at the write pointer and advance it (mod DEPTH).
  - Capture is registered: strobe in cycle t gives out_valid=1 in cycle t+1 if the buffer was empty.
- Free-slot rule: a slot counts as free if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (out_valid & out_ready & out_last). A simultaneous push and pop when full is accepted.
- Drop:
  - rounder_valid=1 with no free slot: tile discarded.
  - overflow is set next cycle.
  - drop_count increments, saturating at 255.
  - Stored tiles are not corrupted.
- Serialize:
  - out_valid = (count != 0).
  - out_data, out_tag and out_row come from the head slot, row = beat index; they are driven from storage with no combinational path from array_out.
  - Beat handshake: out_valid & out_ready advances the beat index.
  - At beat ROWS-1 (out_last=1), the handshake pops the head, advances the read pointer, and resets beat index to 0.
- Stall: while out_valid=1 and out_ready=0, out_data, out_row, out_tag and out_last hold stable. A new capture never alters the head slot.
- Throughput: one beat per cycle sustained; back-to-back tiles with no bubble between the last beat of one tile and row 0 of the next.
- overflow_clr:
  - Clears overflow and drop_count next cycle.
  - If a drop occurs in the same cycle, set wins: overflow=1, drop_count=1.
- Ignored inputs: array_out and round_number are ignored when rounder_valid=0.
- busy = (count != 0).
- Widths: count is $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Decomposition:
- Shared package pe_pkg:
  - DW, COLS, ROWS, TAG_W=3
  - typedef pe_tile_t = logic [ROWS-1:0][COLS-1:0][DW-1:0]
  - typedef pe_row_t = logic [COLS-1:0][DW-1:0]
  - Used by pe_array and this block.
- One natural sub-module: tile_fifo, a DEPTH-entry storage of {tag, tile} with push/pop, full/empty and the same-cycle push-when-full-with-pop rule. pe_array_drain adds the beat serializer, drop logic and counters.

Test Plan:
- Single tile: rounder_valid with round_number=5 and tile[r][n]=r*256+n, out_ready=1 -> out_valid from t+1. Beat 0 carries row 0 (lane n = 0x0000+n), tag 5, last=0. Beat 1 carries row 1 (lane n = 0x0100+n), tag 5, last=1. busy=0 after.
- Back-pressure hold: out_ready=0 for 10 cycles after capture -> out_data, out_tag and out_row stable at row 0. Release -> 2 beats in 2 consecutive cycles.
- Fill and drop: out_ready=0, three strobes with tags 1, 2, 3 -> tags 1 and 2 stored, tag 3 dropped, overflow=1, drop_count=1. Release -> beats tag1r0, tag1r1, tag2r0, tag2r1.
- Push-pop when full: buffer full with tags 1 and 2, strobe tag 3 in the same cycle as tag 1's last-beat handshake -> tag 3 accepted, overflow stays 0, output order 1, 2, 3.
- Clear vs drop: overflow_clr=1 coincident with a drop -> overflow=1, drop_count=1. Next overflow_clr alone -> both 0.
- Reset mid-stream: rst_n=0 for 1 cycle after beat 0 of a tile -> all outputs 0. Following tag 4 tile emits cleanly from row 0.
